// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encoding for the EX-stage ALU and the control decoder.
package alu_pkg;
    typedef logic [2:0] alu_op_t;
    localparam alu_op_t ALU_ADD  = 3'b000;
    localparam alu_op_t ALU_SUB  = 3'b001;
    localparam alu_op_t ALU_AND  = 3'b010;
    localparam alu_op_t ALU_OR   = 3'b011;
    localparam alu_op_t ALU_SLT  = 3'b100;
    localparam alu_op_t ALU_XOR  = 3'b101;
    localparam alu_op_t ALU_NOR  = 3'b110;
    localparam alu_op_t ALU_SLTU = 3'b111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath with zero detect.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
            default:  o_result = '0;
        endcase
    end
    assign o_zero = (o_result == '0);
endmodule

// File: rtl/alu.sv
// alu: registered EX-stage ALU; one op per cycle, 1-cycle latency, valid travels with data.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          alu_control,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);
    logic [WIDTH-1:0] w_result;
    logic             w_zero;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (a),
        .i_b      (b),
        .i_op     (alu_control),
        .o_result (w_result),
        .o_zero   (w_zero)
    );

    // result/zero only load on valid ops so idle cycles never toggle them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_zero   <= w_zero;
            end
        end
    end

    assign out_valid  = r_valid;
    assign alu_result = r_result;
    assign zero       = r_zero;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  alu_control = '0;
    logic        out_valid;
    logic [31:0] alu_result;
    logic        zero;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_r;
    logic        exp_z;
    logic        exp_v;

    alu #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .alu_result  (alu_result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] t;
        case (op)
            3'd0: t = 64'(ux + uy);
            3'd1: t = 64'(ux - uy);
            3'd2: t = {32'b0, x & y};
            3'd3: t = {32'b0, x | y};
            3'd4: t = (sx < sy) ? 64'd1 : 64'd0;
            3'd5: t = {32'b0, x ^ y};
            3'd6: t = {32'b0, ~(x | y)};
            default: t = (ux < uy) ? 64'd1 : 64'd0;
        endcase
        return t[31:0];
    endfunction

    task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input logic v);
        a = x;
        b = y;
        alu_control = op;
        in_valid = v;
        if (v) begin
            exp_r = model(x, y, op);
            exp_z = (exp_r == 32'd0);
        end
        exp_v = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        exp_v = 1'b0; exp_r = '0; exp_z = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: got v=%b r=%h z=%b want v=0 r=0 z=1", out_valid, alu_result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($urandom, $urandom, 3'($urandom), 1'b0);
            checks++;
            if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle[%0d]: got v=%b r=%h z=%b want v=0 r=0 z=1", i, out_valid, alu_result, zero);
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] ta [3] = '{32'd10, 32'd10, 32'd10};
        logic [31:0] tb [3] = '{32'd5, 32'd5, 32'd10};
        logic [2:0]  to [3] = '{3'b000, 3'b001, 3'b001};
        logic [31:0] tr [3] = '{32'd15, 32'd5, 32'd0};
        for (int i = 0; i < 3; i++) begin
            a = ta[i]; b = tb[i]; alu_control = to[i]; in_valid = 1'b1;
            #2;
            checks++;
            if (alu_result !== exp_r || out_valid !== exp_v) begin
                failures++;
                $display("FAIL arith_early[%0d]: got r=%h v=%b want r=%h v=%b", i, alu_result, out_valid, exp_r, exp_v);
            end
            step(ta[i], tb[i], to[i], 1'b1);
            checks++;
            if (alu_result !== tr[i] || zero !== (tr[i] == 0) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL arith[%0d]: got r=%h z=%b v=%b want r=%h z=%b v=1", i, alu_result, zero, out_valid, tr[i], tr[i] == 0);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0]  to [4] = '{3'b010, 3'b011, 3'b101, 3'b110};
        logic [31:0] tr [4] = '{32'h8, 32'hE, 32'h6, 32'hFFFF_FFF1};
        for (int i = 0; i < 4; i++) begin
            step(32'hC, 32'hA, to[i], 1'b1);
            checks++;
            if (alu_result !== tr[i] || zero !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL logic[%0d]: got r=%h z=%b v=%b want r=%h z=0 v=1", i, alu_result, zero, out_valid, tr[i]);
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] ta [6] = '{32'd5, 32'd10, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7};
        logic [31:0] tb [6] = '{32'd10, 32'd5, 32'd0, 32'd0, 32'd7, 32'd7};
        logic [2:0]  to [6] = '{3'b100, 3'b100, 3'b100, 3'b111, 3'b100, 3'b111};
        logic [31:0] tr [6] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            step(ta[i], tb[i], to[i], 1'b1);
            checks++;
            if (alu_result !== tr[i] || zero !== (tr[i] == 0)) begin
                failures++;
                $display("FAIL compare[%0d]: got r=%h z=%b want r=%h z=%b", i, alu_result, zero, tr[i], tr[i] == 0);
            end
        end
    endtask

    task automatic test_wrap();
        step(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b1);
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL wrap_add: got r=%h z=%b want r=0 z=1", alu_result, zero);
        end
        step(32'd0, 32'd1, 3'b001, 1'b1);
        checks++;
        if (alu_result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
            failures++;
            $display("FAIL wrap_sub: got r=%h z=%b want r=ffffffff z=0", alu_result, zero);
        end
    endtask

    task automatic test_hold_reset();
        step(32'd3, 32'd4, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step($urandom, $urandom, 3'($urandom), 1'b0);
            checks++;
            if (out_valid !== 1'b0 || alu_result !== 32'd7 || zero !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: got v=%b r=%h z=%b want v=0 r=7 z=0", i, out_valid, alu_result, zero);
            end
        end
        step(32'd9, 32'd1, 3'b000, 1'b1);
        a = 32'd100; b = 32'd1; alu_control = 3'b000; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL midop_reset: got v=%b r=%h z=%b want v=0 r=0 z=1", out_valid, alu_result, zero);
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        exp_v = 1'b0; exp_r = '0; exp_z = 1'b1;
        step(32'd100, 32'd1, 3'b000, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL midop_discard: got v=%b r=%h z=%b want v=0 r=0 z=1", out_valid, alu_result, zero);
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? x : 32'($urandom);
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            step(x, y, 3'($urandom), ($urandom_range(0, 3) != 0));
            checks++;
            if (out_valid !== exp_v || alu_result !== exp_r || zero !== exp_z) begin
                failures++;
                $display("FAIL random[%0d]: op=%0d a=%h b=%h got v=%b r=%h z=%b want v=%b r=%h z=%b",
                         i, alu_control, a, b, out_valid, alu_result, zero, exp_v, exp_r, exp_z);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_compare();
        test_wrap();
        test_hold_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
